// File: rtl/pointwise_pe_acc.sv
// rtl/pointwise_pe_acc.sv - pipelined pointwise multiply/adder-tree accumulator with requantiser
module pointwise_pe_acc #(
    parameter int DATA_WIDTH  = 16,
    parameter int ICP         = 8,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+8,
    parameter int TREE_STAGES = $clog2(ICP)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [DATA_WIDTH*ICP-1:0] data,
    input  logic [DATA_WIDTH*ICP-1:0] weight,
    input  logic [7:0]                input_channel_sel,
    input  logic [7:0]                output_channel_sel,
    input  logic [4:0]                cfg_shift,
    input  logic                      cfg_relu,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      result_acc,
    output logic [DATA_WIDTH-1:0]     result_q,
    output logic [7:0]                input_channel_sel_out,
    output logic [7:0]                output_channel_sel_out
);

    localparam int PW    = 2*DATA_WIDTH;
    localparam int SW    = PW + TREE_STAGES;
    localparam int NMETA = TREE_STAGES + 2;
    localparam int RW    = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] QMAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] QMIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic [7:0] ich;
        logic [7:0] och;
        logic [4:0] shift;
        logic       relu;
    } meta_t;

    typedef struct packed {
        logic       valid;
        logic       last;
        logic [7:0] ich;
        logic [7:0] och;
        logic [4:0] shift;
        logic       relu;
    } acc_meta_t;

    logic                          en;
    meta_t                         in_meta;
    meta_t                         meta_q [NMETA];
    acc_meta_t                     acc_meta_q;
    logic [DATA_WIDTH*ICP-1:0]     data_q;
    logic [DATA_WIDTH*ICP-1:0]     weight_q;
    logic signed [PW-1:0]          prod_q [ICP];
    logic signed [SW-1:0]          tree_sum;
    logic signed [ACC_WIDTH-1:0]   tree_ext;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic signed [RW-1:0]          rnd;
    logic signed [RW-1:0]          shifted;
    logic [DATA_WIDTH-1:0]         q_sat;
    logic                          out_valid_q;
    logic [ACC_WIDTH-1:0]          result_acc_q;
    logic [DATA_WIDTH-1:0]         result_q_q;
    logic [7:0]                    ich_out_q;
    logic [7:0]                    och_out_q;

    // A held result freezes the whole pipeline, so nothing in flight is ever dropped.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        in_meta       = '0;
        in_meta.valid = in_valid;
        in_meta.first = in_first;
        in_meta.last  = in_last;
        in_meta.ich   = input_channel_sel;
        in_meta.och   = output_channel_sel;
        in_meta.shift = cfg_shift;
        in_meta.relu  = cfg_relu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NMETA; i++) meta_q[i] <= '0;
            acc_meta_q <= '0;
        end else if (en) begin
            meta_q[0] <= in_meta;
            for (int i = 1; i < NMETA; i++) meta_q[i] <= meta_q[i-1];
            acc_meta_q.valid <= meta_q[NMETA-1].valid;
            acc_meta_q.last  <= meta_q[NMETA-1].last;
            acc_meta_q.ich   <= meta_q[NMETA-1].ich;
            acc_meta_q.och   <= meta_q[NMETA-1].och;
            acc_meta_q.shift <= meta_q[NMETA-1].shift;
            acc_meta_q.relu  <= meta_q[NMETA-1].relu;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_q   <= data;
            weight_q <= weight;
            for (int i = 0; i < ICP; i++)
                prod_q[i] <= $signed(data_q[i*DATA_WIDTH +: DATA_WIDTH]) *
                             $signed(weight_q[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Each tree level grows by exactly one bit so no pairwise sum can overflow.
    for (genvar l = 0; l < TREE_STAGES; l++) begin : g_lvl
        localparam int N = ICP >> (l + 1);
        localparam int W = PW + l + 1;
        logic signed [W-2:0] op [2*N];
        logic signed [W-1:0] sum_q [N];
        for (genvar j = 0; j < 2*N; j++) begin : g_op
            if (l == 0) begin : g_leaf
                assign op[j] = prod_q[j];
            end else begin : g_inner
                assign op[j] = g_lvl[l-1].sum_q[j];
            end
        end
        always_ff @(posedge clk) begin
            if (en) begin
                for (int j = 0; j < N; j++)
                    sum_q[j] <= {op[2*j][W-2], op[2*j]} + {op[2*j+1][W-2], op[2*j+1]};
            end
        end
    end

    assign tree_sum = g_lvl[TREE_STAGES-1].sum_q[0];
    assign tree_ext = ACC_WIDTH'(tree_sum);

    always_comb begin
        acc_d = acc_q;
        if (meta_q[NMETA-1].valid) begin
            acc_d = meta_q[NMETA-1].first ? tree_ext : acc_q + tree_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else if (en) acc_q <= acc_d;
    end

    // One extra bit keeps the half-LSB rounding term from wrapping the accumulator.
    always_comb begin
        rnd = {acc_q[ACC_WIDTH-1], acc_q};
        if (acc_meta_q.shift != 5'd0) rnd = rnd + (RW'(1) << (acc_meta_q.shift - 5'd1));
        shifted = rnd >>> acc_meta_q.shift;
        if (acc_meta_q.relu && shifted[RW-1]) shifted = '0;
        if (shifted > QMAX)      q_sat = QMAX[DATA_WIDTH-1:0];
        else if (shifted < QMIN) q_sat = QMIN[DATA_WIDTH-1:0];
        else                     q_sat = shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            result_acc_q <= '0;
            result_q_q   <= '0;
            ich_out_q    <= '0;
            och_out_q    <= '0;
        end else if (en) begin
            out_valid_q <= acc_meta_q.valid && acc_meta_q.last;
            if (acc_meta_q.valid && acc_meta_q.last) begin
                result_acc_q <= acc_q;
                result_q_q   <= q_sat;
                ich_out_q    <= acc_meta_q.ich;
                och_out_q    <= acc_meta_q.och;
            end
        end
    end

    assign out_valid              = out_valid_q;
    assign result_acc             = result_acc_q;
    assign result_q               = result_q_q;
    assign input_channel_sel_out  = ich_out_q;
    assign output_channel_sel_out = och_out_q;

endmodule
